stack_machine_sequencer: RTL and testbench
==========================================

Name: stack_machine_sequencer

Overview:
- Run-control block for the 8-bit stack machine core.
- Loads 12-bit instruction words into the core's 32-entry instruction memory over a valid/ready host port.
- Sequences execution: run, single-step, halt and breakpoint, by gating the core clock-enable.
- Guards execution against stack overflow/underflow, illegal opcodes and runaway programs, and reports status to the host.

Parameters:
- PC_W, 5: instruction address width (32-word imem).
- INST_W, 12: instruction width; opcode is bits [11:8], operand is bits [7:0].
- SP_W, 3: core stack-pointer width; usable depth is 2^SP_W-1 = 7.
- CYC_W, 16: cycle-counter width.
- MAX_CYCLES, 16'hFFFF: watchdog limit on executed instructions per RUN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  host command strobe
- cmd_ready  out  1  high only in IDLE or PAUSED
- cmd  in  2  0=LOAD, 1=RUN, 2=STEP, 3=ABORT
- cmd_len  in  PC_W+1  LOAD word count, 1..32
- ld_valid  in  1  load word valid
- ld_ready  out  1  high in LOAD
- ld_data  in  INST_W  instruction word
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint pc
- core_pc  in  PC_W  current core pc
- core_sp  in  SP_W  current core sp
- core_en  out  1  core advances one instruction when high
- core_clr  out  1  one-cycle synchronous clear of core pc/sp/flags
- imem_we  out  1  instruction write strobe
- imem_waddr  out  PC_W  write address
- imem_wdata  out  INST_W  write data
- imem_rdata  in  INST_W  instruction at core_pc
- busy  out  1  high in LOAD/RUN/STEP
- done  out  1  program ran off its end
- fault  out  1  sticky fault
- fault_code  out  3  0 none, 1 overflow, 2 underflow, 3 illegal op, 4 watchdog
- cycle_count  out  CYC_W  instructions executed since last LOAD or RUN-from-IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except cmd_ready=1. prog_len=0.
- States: IDLE, LOAD, RUN, STEP, PAUSED, FAULT.
- Command acceptance: a command is accepted on cmd_valid & cmd_ready. cmd_valid is ignored in all other states, except that ABORT is accepted in any state.
- IDLE:
  - LOAD: latch prog_len=cmd_len and zero the write pointer -> LOAD. cmd_len=0 is ignored.
  - RUN: pulse core_clr and zero cycle_count -> RUN.
  - STEP: pulse core_clr -> PAUSED.
  - ABORT: no effect.
- LOAD:
  - On each ld_valid&ld_ready: imem_we=1, imem_waddr=wptr, imem_wdata=ld_data (same cycle, combinational); wptr++.
  - After word prog_len: clear done and fault, pulse core_clr -> IDLE.
  - ABORT: -> IDLE; words already written remain.
- Per-instruction check in RUN/STEP: combinational on op=imem_rdata[11:8] and core_sp.
  - ops 0,1 (push) with core_sp==7 -> overflow.
  - ops 2,3 with core_sp==0 -> underflow.
  - ops 6,7 with core_sp<2 -> underflow.
  - op>7 -> illegal op.
  - ops 4,5 are checked like op 3 (sp>=1 required) regardless of flags.
  - A failing check holds core_en=0 that cycle; fault=1, fault_code latched -> FAULT.
- RUN: each cycle evaluates stop conditions in this priority:
  1. check fail -> FAULT.
  2. core_pc >= prog_len -> done=1 -> IDLE.
  3. bp_en & core_pc==bp_addr, and not the first cycle after resume -> PAUSED.
  4. cycle_count==MAX_CYCLES -> fault_code=4 -> FAULT.
  - If none fire: core_en=1 and cycle_count++ (saturating).
- PAUSED:
  - RUN: resume; the breakpoint is masked for exactly one cycle.
  - STEP -> STEP.
  - ABORT -> IDLE without core_clr.
- STEP: exactly one cycle. Apply the same check and pc-end test; if both pass, core_en=1 -> PAUSED.
- FAULT: core_en=0; only ABORT is accepted, which clears fault and fault_code -> IDLE. fault is sticky until ABORT or LOAD completion.
- Latency: core_en is high in the same cycle the RUN state is entered, one cycle after command acceptance.
- prog_len=32: pc never reaches prog_len; the program ends only by breakpoint, fault, watchdog or ABORT.
- Simultaneous ABORT with a stop condition: ABORT wins.

Decomposition:
- Shared package stack_machine_pkg holds:
  - opcode localparams (PUSHC..SUB=0..7)
  - command codes
  - fault codes
  - state enum
- The ISA constants are reused by the core.
- One sub-module: stack_machine_guard. It is combinational (op, sp -> ok, fault_code) and holds all stack-bound and opcode legality rules.

Test Plan:
- Load 3 words {0x005,0x003,0x600} with cmd_len=3 -> imem_we pulses at addrs 0,1,2 with matching data; then RUN -> core_en high 3 cycles, done=1, cycle_count=3, returns to IDLE.
- Program of 8 PUSHC -> core_en for 7 cycles; at core_sp=7 fault=1, fault_code=1, core_en=0.
- First instruction 0x600 (ADD) with core_sp=0 -> fault_code=2 in the first RUN cycle, zero cycles executed; ABORT -> fault=0, IDLE.
- Instruction 0x9xx -> fault_code=3. Loop program 0x000 then 0x300, with MAX_CYCLES=20 -> fault_code=4 with cycle_count=20.
- bp_en=1, bp_addr=2 -> PAUSED with core_pc=2 after 2 instructions; STEP -> one core_en pulse; RUN -> resumes without re-hitting the breakpoint.
- Assert rst mid-LOAD after 2 of 4 words -> all outputs 0 and IDLE immediately; a subsequent full LOAD works.

Source files
------------

// File: rtl/stack_machine_pkg.sv
// Shared ISA, command, fault and FSM encodings for the 8-bit stack machine and its run-control block.
package stack_machine_pkg;

    localparam int unsigned PC_W   = 5;
    localparam int unsigned INST_W = 12;
    localparam int unsigned SP_W   = 3;
    localparam int unsigned CYC_W  = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned LEN_W  = PC_W + 1;

    // Opcodes live in inst[11:8]; anything above SUB is illegal.
    localparam logic [OP_W-1:0] OP_PUSHC = 4'd0;
    localparam logic [OP_W-1:0] OP_PUSHM = 4'd1;
    localparam logic [OP_W-1:0] OP_POP   = 4'd2;
    localparam logic [OP_W-1:0] OP_JMP   = 4'd3;
    localparam logic [OP_W-1:0] OP_JZ    = 4'd4;
    localparam logic [OP_W-1:0] OP_JNZ   = 4'd5;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd6;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd7;

    typedef logic [1:0] cmd_t;
    localparam cmd_t CMD_LOAD  = 2'd0;
    localparam cmd_t CMD_RUN   = 2'd1;
    localparam cmd_t CMD_STEP  = 2'd2;
    localparam cmd_t CMD_ABORT = 2'd3;

    typedef logic [2:0] fault_code_t;
    localparam fault_code_t FC_NONE      = 3'd0;
    localparam fault_code_t FC_OVERFLOW  = 3'd1;
    localparam fault_code_t FC_UNDERFLOW = 3'd2;
    localparam fault_code_t FC_ILLEGAL   = 3'd3;
    localparam fault_code_t FC_WATCHDOG  = 3'd4;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_RUN    = 3'd2;
    localparam state_t ST_STEP   = 3'd3;
    localparam state_t ST_PAUSED = 3'd4;
    localparam state_t ST_FAULT  = 3'd5;

endpackage

// File: rtl/stack_machine_sequencer_if.sv
// Host command and program-load port of the stack machine sequencer.
interface stack_machine_sequencer_if;
    import stack_machine_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_t              cmd;
    logic [LEN_W-1:0]  cmd_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [INST_W-1:0] ld_data;

    modport master (
        output cmd_valid, cmd, cmd_len, ld_valid, ld_data,
        input  cmd_ready, ld_ready
    );

    modport slave (
        input  cmd_valid, cmd, cmd_len, ld_valid, ld_data,
        output cmd_ready, ld_ready
    );

endinterface

// File: rtl/stack_machine_guard.sv
// Combinational legality check of the instruction at the core pc against the current stack depth.
module stack_machine_guard
    import stack_machine_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [SP_W-1:0] sp,
    output logic            ok_c,
    output fault_code_t     code_c
);

    localparam logic [SP_W-1:0] SP_FULL = '1;

    always_comb begin
        code_c = FC_NONE;
        case (op)
            OP_PUSHC, OP_PUSHM:            if (sp == SP_FULL) code_c = FC_OVERFLOW;
            OP_POP, OP_JMP, OP_JZ, OP_JNZ: if (sp == '0) code_c = FC_UNDERFLOW;
            OP_ADD, OP_SUB:                if (sp < SP_W'(2)) code_c = FC_UNDERFLOW;
            default:                       code_c = FC_ILLEGAL;
        endcase
        ok_c = (code_c == FC_NONE);
    end

endmodule

// File: rtl/stack_machine_sequencer.sv
// Run-control for the stack machine core: program load, run/step/breakpoint sequencing and
// execution guarding through the core clock-enable.
module stack_machine_sequencer
    import stack_machine_pkg::*;
#(
    parameter logic [CYC_W-1:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    stack_machine_sequencer_if.slave host,
    input  logic                     bp_en,
    input  logic [PC_W-1:0]          bp_addr,
    input  logic [PC_W-1:0]          core_pc,
    input  logic [SP_W-1:0]          core_sp,
    output logic                     core_en,
    output logic                     core_clr,
    output logic                     imem_we,
    output logic [PC_W-1:0]          imem_waddr,
    output logic [INST_W-1:0]        imem_wdata,
    input  logic [INST_W-1:0]        imem_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output fault_code_t              fault_code,
    output logic [CYC_W-1:0]         cycle_count
);

    state_t           state, state_nx;
    logic [LEN_W-1:0] prog_len, prog_len_nx;
    logic [LEN_W-1:0] wptr, wptr_nx, wptr_inc;
    logic [CYC_W-1:0] cyc_nx, cyc_inc;
    logic             done_nx, fault_nx;
    fault_code_t      fault_code_nx;
    logic             bp_mask, bp_mask_nx;

    logic             chk_ok;
    fault_code_t      chk_code;
    logic             cmd_acc, abort, pc_end, bp_hit, wdog;
    logic             unused_operand;

    stack_machine_guard u_guard (
        .op     (imem_rdata[INST_W-1 -: OP_W]),
        .sp     (core_sp),
        .ok_c   (chk_ok),
        .code_c (chk_code)
    );

    assign unused_operand = ^imem_rdata[INST_W-OP_W-1:0];

    assign host.cmd_ready = (state == ST_IDLE) || (state == ST_PAUSED);
    assign host.ld_ready  = (state == ST_LOAD);
    assign busy           = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_STEP);

    assign cmd_acc  = host.cmd_valid & host.cmd_ready;
    assign abort    = host.cmd_valid & (host.cmd == CMD_ABORT);
    assign pc_end   = {1'b0, core_pc} >= prog_len;
    assign bp_hit   = bp_en & (core_pc == bp_addr) & ~bp_mask;
    assign wdog     = (cycle_count == MAX_CYCLES);
    assign wptr_inc = wptr + LEN_W'(1);
    assign cyc_inc  = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);
    assign imem_waddr = wptr[PC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            prog_len    <= '0;
            wptr        <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            bp_mask     <= 1'b0;
        end else begin
            state       <= state_nx;
            prog_len    <= prog_len_nx;
            wptr        <= wptr_nx;
            cycle_count <= cyc_nx;
            done        <= done_nx;
            fault       <= fault_nx;
            fault_code  <= fault_code_nx;
            bp_mask     <= bp_mask_nx;
        end
    end

    // Next state plus the same-cycle strobes to the core and imem.
    always_comb begin
        state_nx      = state;
        prog_len_nx   = prog_len;
        wptr_nx       = wptr;
        cyc_nx        = cycle_count;
        done_nx       = done;
        fault_nx      = fault;
        fault_code_nx = fault_code;
        bp_mask_nx    = bp_mask;
        core_en       = 1'b0;
        core_clr      = 1'b0;
        imem_we       = 1'b0;
        imem_wdata    = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (host.cmd)
                        CMD_LOAD: begin
                            if (host.cmd_len != '0) begin
                                prog_len_nx = host.cmd_len;
                                wptr_nx     = '0;
                                cyc_nx      = '0;
                                state_nx    = ST_LOAD;
                            end
                        end
                        CMD_RUN: begin
                            core_clr   = 1'b1;
                            cyc_nx     = '0;
                            bp_mask_nx = 1'b0;
                            state_nx   = ST_RUN;
                        end
                        CMD_STEP: begin
                            core_clr = 1'b1;
                            state_nx = ST_PAUSED;
                        end
                        default: ;
                    endcase
                end
            end

            ST_LOAD: begin
                if (host.ld_valid) begin
                    imem_we    = 1'b1;
                    imem_wdata = host.ld_data;
                    wptr_nx    = wptr_inc;
                end
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (host.ld_valid && (wptr_inc == prog_len)) begin
                    done_nx       = 1'b0;
                    fault_nx      = 1'b0;
                    fault_code_nx = FC_NONE;
                    core_clr      = 1'b1;
                    state_nx      = ST_IDLE;
                end
            end

            ST_RUN: begin
                bp_mask_nx = 1'b0;
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!chk_ok) begin
                    fault_nx      = 1'b1;
                    fault_code_nx = chk_code;
                    state_nx      = ST_FAULT;
                end else if (pc_end) begin
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (bp_hit) begin
                    state_nx = ST_PAUSED;
                end else if (wdog) begin
                    fault_nx      = 1'b1;
                    fault_code_nx = FC_WATCHDOG;
                    state_nx      = ST_FAULT;
                end else begin
                    core_en = 1'b1;
                    cyc_nx  = cyc_inc;
                end
            end

            ST_PAUSED: begin
                if (cmd_acc) begin
                    case (host.cmd)
                        CMD_RUN: begin
                            bp_mask_nx = 1'b1;
                            state_nx   = ST_RUN;
                        end
                        CMD_STEP:  state_nx = ST_STEP;
                        CMD_ABORT: state_nx = ST_IDLE;
                        default: ;
                    endcase
                end
            end

            ST_STEP: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (!chk_ok) begin
                    fault_nx      = 1'b1;
                    fault_code_nx = chk_code;
                    state_nx      = ST_FAULT;
                end else if (pc_end) begin
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    core_en  = 1'b1;
                    cyc_nx   = cyc_inc;
                    state_nx = ST_PAUSED;
                end
            end

            ST_FAULT: begin
                if (abort) begin
                    fault_nx      = 1'b0;
                    fault_code_nx = FC_NONE;
                    state_nx      = ST_IDLE;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_machine_sequencer.sv
// Self-checking bench: a tiny behavioural core and imem around the sequencer, with write and
// run-result scoreboards.
module tb_stack_machine_sequencer;
    import stack_machine_pkg::*;

    localparam logic [CYC_W-1:0] WDOG_LIMIT = 16'd20;

    typedef struct packed {
        logic [PC_W-1:0]   addr;
        logic [INST_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic              done;
        logic              fault;
        fault_code_t       code;
        logic [CYC_W-1:0]  cyc;
        logic [7:0]        en;
        logic [PC_W-1:0]   pc;
        logic              rdy;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_machine_sequencer_if hif ();

    logic              bp_en = 1'b0;
    logic [PC_W-1:0]   bp_addr = '0;
    logic [PC_W-1:0]   core_pc;
    logic [SP_W-1:0]   core_sp;
    logic [INST_W-1:0] imem_rdata;
    logic              core_en, core_clr, imem_we;
    logic [PC_W-1:0]   imem_waddr;
    logic [INST_W-1:0] imem_wdata;
    logic              busy, done, fault;
    fault_code_t       fault_code;
    logic [CYC_W-1:0]  cycle_count;

    stack_machine_sequencer #(.MAX_CYCLES(WDOG_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hif),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .core_pc     (core_pc),
        .core_sp     (core_sp),
        .core_en     (core_en),
        .core_clr    (core_clr),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .imem_rdata  (imem_rdata),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_count (cycle_count)
    );

    logic [INST_W-1:0] mem [32] = '{default: '0};
    logic [OP_W-1:0]   op;

    always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
    assign imem_rdata = mem[core_pc];
    assign op = imem_rdata[INST_W-1 -: OP_W];

    // Behavioural core: push grows sp, JMP pops and jumps to the operand, everything else pops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_pc <= '0;
            core_sp <= '0;
        end else if (core_clr) begin
            core_pc <= '0;
            core_sp <= '0;
        end else if (core_en) begin
            case (op)
                OP_PUSHC, OP_PUSHM: begin
                    core_sp <= core_sp + SP_W'(1);
                    core_pc <= core_pc + PC_W'(1);
                end
                OP_JMP: begin
                    core_sp <= core_sp - SP_W'(1);
                    core_pc <= imem_rdata[PC_W-1:0];
                end
                default: begin
                    core_sp <= core_sp - SP_W'(1);
                    core_pc <= core_pc + PC_W'(1);
                end
            endcase
        end
    end

    int en_cnt = 0;
    always @(negedge clk) if (core_en === 1'b1) en_cnt = en_cnt + 1;

    int checks = 0;
    int errors = 0;
    wr_t  wr_q [$];
    res_t res_q [$];
    logic [INST_W-1:0] prog [32];

    task automatic send_cmd(input cmd_t c, input logic [LEN_W-1:0] len);
        @(posedge clk); #1;
        hif.cmd_valid = 1'b1;
        hif.cmd       = c;
        hif.cmd_len   = len;
        @(posedge clk); #1;
        hif.cmd_valid = 1'b0;
    endtask

    // Declares a program of len words but only streams the first nsend of them.
    task automatic load_prog(input string name, input int len, input int nsend);
        wr_t exp;
        send_cmd(CMD_LOAD, LEN_W'(len));
        for (int i = 0; i < nsend; i++) begin
            hif.ld_valid = 1'b1;
            hif.ld_data  = prog[i];
            wr_q.push_back({PC_W'(i), prog[i]});
            @(negedge clk);
            exp = wr_q.pop_front();
            checks++;
            if (imem_we !== 1'b1 || {imem_waddr, imem_wdata} !== exp) begin
                errors++;
                $display("FAIL %s write[%0d]: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                         name, i, imem_we, imem_waddr, imem_wdata, exp.addr, exp.data);
            end
            @(posedge clk); #1;
        end
        hif.ld_valid = 1'b0;
        if (nsend == len) begin
            @(negedge clk);
            checks++;
            if ({hif.cmd_ready, busy, done, fault} !== 4'b1000) begin
                errors++;
                $display("FAIL %s load_end: ready/busy/done/fault=%b required 1000",
                         name, {hif.cmd_ready, busy, done, fault});
            end
        end
    endtask

    task automatic exec_check(input string name, input cmd_t c, input res_t exp_in);
        res_t exp;
        int   base;
        int   n;
        logic [7:0] en_got;
        res_q.push_back(exp_in);
        base = en_cnt;
        send_cmd(c, '0);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        exp    = res_q.pop_front();
        en_got = 8'(en_cnt - base);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
        checks++;
        if ({done, fault, fault_code} !== {exp.done, exp.fault, exp.code}) begin
            errors++;
            $display("FAIL %s status: done=%b fault=%b code=%0d, required done=%b fault=%b code=%0d",
                     name, done, fault, fault_code, exp.done, exp.fault, exp.code);
        end
        checks++;
        if (cycle_count !== exp.cyc || en_got !== exp.en) begin
            errors++;
            $display("FAIL %s count: cycle_count=%0d core_en_pulses=%0d, required %0d and %0d",
                     name, cycle_count, en_got, exp.cyc, exp.en);
        end
        checks++;
        if (core_pc !== exp.pc || hif.cmd_ready !== exp.rdy || core_en !== 1'b0) begin
            errors++;
            $display("FAIL %s stop: pc=%0d cmd_ready=%b core_en=%b, required pc=%0d cmd_ready=%b core_en=0",
                     name, core_pc, hif.cmd_ready, core_en, exp.pc, exp.rdy);
        end
    endtask

    task automatic do_abort(input string name);
        send_cmd(CMD_ABORT, '0);
        @(negedge clk);
        checks++;
        if ({fault, fault_code, busy, hif.cmd_ready} !== {1'b0, FC_NONE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL %s abort: fault=%b code=%0d busy=%b cmd_ready=%b, required 0 0 0 1",
                     name, fault, fault_code, busy, hif.cmd_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({core_en, core_clr, imem_we, imem_waddr, imem_wdata, busy, done, fault, fault_code,
             cycle_count, hif.ld_ready} !== '0 || hif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s reset_outputs: en=%b clr=%b we=%b waddr=%0d wdata=%h busy=%b done=%b fault=%b code=%0d cyc=%0d ld_ready=%b cmd_ready=%b, required all 0 and cmd_ready=1",
                     name, core_en, core_clr, imem_we, imem_waddr, imem_wdata, busy, done, fault,
                     fault_code, cycle_count, hif.ld_ready, hif.cmd_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_run();
        prog[0] = 12'h005; prog[1] = 12'h003; prog[2] = 12'h600;
        load_prog("load3", 3, 3);
        exec_check("run3", CMD_RUN,
                   '{done: 1'b1, fault: 1'b0, code: FC_NONE, cyc: 16'd3, en: 8'd3, pc: 5'd3, rdy: 1'b1});
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) prog[i] = 12'h000 | 12'(i);
        load_prog("load_push8", 8, 8);
        exec_check("overflow", CMD_RUN,
                   '{done: 1'b0, fault: 1'b1, code: FC_OVERFLOW, cyc: 16'd7, en: 8'd7, pc: 5'd7, rdy: 1'b0});
        do_abort("overflow");
    endtask

    task automatic test_underflow_abort();
        prog[0] = 12'h600;
        load_prog("load_add", 1, 1);
        exec_check("underflow", CMD_RUN,
                   '{done: 1'b0, fault: 1'b1, code: FC_UNDERFLOW, cyc: 16'd0, en: 8'd0, pc: 5'd0, rdy: 1'b0});
        do_abort("underflow");
    endtask

    task automatic test_illegal();
        prog[0] = 12'h9AB;
        load_prog("load_illegal", 1, 1);
        exec_check("illegal", CMD_RUN,
                   '{done: 1'b0, fault: 1'b1, code: FC_ILLEGAL, cyc: 16'd0, en: 8'd0, pc: 5'd0, rdy: 1'b0});
        do_abort("illegal");
    endtask

    task automatic test_watchdog();
        prog[0] = 12'h000; prog[1] = 12'h300;
        load_prog("load_loop", 2, 2);
        exec_check("watchdog", CMD_RUN,
                   '{done: 1'b0, fault: 1'b1, code: FC_WATCHDOG, cyc: 16'd20, en: 8'd20, pc: 5'd0, rdy: 1'b0});
        do_abort("watchdog");
    endtask

    task automatic test_breakpoint();
        for (int i = 0; i < 5; i++) prog[i] = 12'h010 + 12'(i);
        bp_en   = 1'b1;
        bp_addr = 5'd2;
        load_prog("load_bp_a", 5, 5);
        exec_check("bp_hit", CMD_RUN,
                   '{done: 1'b0, fault: 1'b0, code: FC_NONE, cyc: 16'd2, en: 8'd2, pc: 5'd2, rdy: 1'b1});
        exec_check("bp_resume", CMD_RUN,
                   '{done: 1'b1, fault: 1'b0, code: FC_NONE, cyc: 16'd5, en: 8'd3, pc: 5'd5, rdy: 1'b1});
        load_prog("load_bp_b", 5, 5);
        exec_check("bp_hit2", CMD_RUN,
                   '{done: 1'b0, fault: 1'b0, code: FC_NONE, cyc: 16'd2, en: 8'd2, pc: 5'd2, rdy: 1'b1});
        exec_check("bp_step", CMD_STEP,
                   '{done: 1'b0, fault: 1'b0, code: FC_NONE, cyc: 16'd3, en: 8'd1, pc: 5'd3, rdy: 1'b1});
        exec_check("bp_run_after_step", CMD_RUN,
                   '{done: 1'b1, fault: 1'b0, code: FC_NONE, cyc: 16'd5, en: 8'd2, pc: 5'd5, rdy: 1'b1});
        bp_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 4; i++) prog[i] = 12'h0A0 + 12'(i);
        load_prog("load_partial", 4, 2);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_load_reset");
        @(negedge clk);
        rst = 1'b0;
        load_prog("load_full", 4, 4);
        exec_check("run_after_reset", CMD_RUN,
                   '{done: 1'b1, fault: 1'b0, code: FC_NONE, cyc: 16'd4, en: 8'd4, pc: 5'd4, rdy: 1'b1});
    endtask

    initial begin
        hif.cmd_valid = 1'b0;
        hif.cmd       = CMD_LOAD;
        hif.cmd_len   = '0;
        hif.ld_valid  = 1'b0;
        hif.ld_data   = '0;
        for (int i = 0; i < 32; i++) prog[i] = '0;

        test_reset();
        test_load_run();
        test_overflow();
        test_underflow_abort();
        test_illegal();
        test_watchdog();
        test_breakpoint();
        test_reset_mid_load();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
